// File: rtl/addr_seq.sv
// rtl/addr_seq.sv - address sequencer with inc/dec/load/add and optional return stack
// Optional return stack enabled by defining ADDR_SEQ_STACK_EN.
module addr_seq #(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 4,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [2:0]                 cmd,
    input  logic [WIDTH-1:0]           x,
    output logic [WIDTH-1:0]           z,
    output logic                       zflag,
    output logic                       carry,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       err
);

    localparam int SPW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        C_NOP  = 3'd0,
        C_INC  = 3'd1,
        C_DEC  = 3'd2,
        C_LOAD = 3'd3,
        C_ADD  = 3'd4,
        C_CALL = 3'd5,
        C_RET  = 3'd6,
        C_CLR  = 3'd7
    } cmd_t;

    cmd_t             op;
    logic [WIDTH-1:0] z_nxt;
    logic             c_nxt;

    assign op = cmd_t'(cmd);

`ifdef ADDR_SEQ_STACK_EN
    // Index width rounded up to a power-of-two array; the spare entries are never written.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] stack [0:(1<<IW)-1];
    logic [SPW-1:0]   sp_q;
    logic [SPW-1:0]   sp_nxt;
    logic             err_q;
    logic             err_nxt;
    logic             push;

    assign sp  = sp_q;
    assign err = err_q;
`else
    assign sp  = '0;
    assign err = 1'b0;
`endif

    always_comb begin
        z_nxt = z;
        c_nxt = 1'b0;
`ifdef ADDR_SEQ_STACK_EN
        sp_nxt  = sp_q;
        err_nxt = err_q;
        push    = 1'b0;
`endif
        case (op)
            C_INC:  {c_nxt, z_nxt} = {1'b0, z} + (WIDTH+1)'(1);
            C_DEC: begin
                z_nxt = z - WIDTH'(1);
                c_nxt = (z == '0);
            end
            C_LOAD: z_nxt = x;
            C_ADD:  {c_nxt, z_nxt} = {1'b0, z} + {1'b0, x};
`ifdef ADDR_SEQ_STACK_EN
            C_CALL: begin
                if (sp_q < SPW'(DEPTH)) begin
                    push   = 1'b1;
                    sp_nxt = sp_q + SPW'(1);
                    z_nxt  = x;
                end else begin
                    err_nxt = 1'b1;
                end
            end
            C_RET: begin
                if (sp_q != '0) begin
                    sp_nxt = sp_q - SPW'(1);
                    z_nxt  = stack[IW'(sp_q - SPW'(1))];
                end else begin
                    err_nxt = 1'b1;
                end
            end
            C_CLR: begin
                z_nxt   = RESET_ADDR;
                sp_nxt  = '0;
                err_nxt = 1'b0;
            end
`else
            C_CALL: z_nxt = x;
            C_RET:  z_nxt = z;
            C_CLR:  z_nxt = RESET_ADDR;
`endif
            default: z_nxt = z;
        endcase
    end

    // zflag is derived from the next address so it always tracks z in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            z     <= RESET_ADDR;
            zflag <= (RESET_ADDR == '0);
            carry <= 1'b0;
`ifdef ADDR_SEQ_STACK_EN
            sp_q  <= '0;
            err_q <= 1'b0;
`endif
        end else if (en) begin
            z     <= z_nxt;
            zflag <= (z_nxt == '0);
            carry <= c_nxt;
`ifdef ADDR_SEQ_STACK_EN
            sp_q  <= sp_nxt;
            err_q <= err_nxt;
`endif
        end
    end

`ifdef ADDR_SEQ_STACK_EN
    always_ff @(posedge clk) begin
        if (!rst && en && push) begin
            stack[IW'(sp_q)] <= z + WIDTH'(1);
        end
    end
`endif

endmodule

// File: doc/addr_seq.md
ADDR_SEQ -- requirements
Module: addr_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, address width in bits (legal 2..32).
REQ-002 SHALL have parameter DEPTH, default 4, return-stack entries (legal 1..16).
REQ-003 SHALL have parameter RESET_ADDR, default 0, address loaded on reset and CLR (WIDTH bits).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-006 SHALL have port en  input  1  command strobe; cmd executes only in cycles with en=1.
REQ-007 SHALL have port cmd  input  3  command: 0 NOP, 1 INC, 2 DEC, 3 LOAD, 4 ADD, 5 CALL, 6 RET, 7 CLR.
REQ-008 SHALL have port x  input  WIDTH  operand (LOAD/CALL target, ADD offset).
REQ-009 SHALL have port z  output  WIDTH  registered current address.
REQ-010 SHALL have port zflag  output  1  registered, 1 when z==0.
REQ-011 SHALL have port carry  output  1  registered wrap flag of last executed command.
REQ-012 SHALL have port sp  output  $clog2(DEPTH+1)  return-stack occupancy, 0..DEPTH.
REQ-013 SHALL have port err  output  1  sticky stack overflow/underflow flag.

Function
REQ-014 SHALL apply every command with 1-cycle latency: z, zflag, carry, sp, err reflect cmd on the clk edge where en=1.
REQ-015 SHALL hold all state when en=0, whatever the value of cmd.
REQ-016 NOP: no state change; carry cleared.
REQ-017 INC: z <= z+1 mod 2^WIDTH; carry=1 only on wrap from all-ones to 0.
REQ-018 DEC: z <= z-1 mod 2^WIDTH; carry=1 only on wrap from 0 to all-ones.
REQ-019 LOAD: z <= x; carry cleared.
REQ-020 ADD: z <= (z+x) mod 2^WIDTH; carry = bit WIDTH of the unsigned sum.
REQ-021 CALL with sp<DEPTH: push z+1 (mod 2^WIDTH) at stack[sp], sp <= sp+1, z <= x; carry cleared.
REQ-022 CALL with sp==DEPTH (full): no push, z and sp unchanged, err <= 1.
REQ-023 RET with sp>0: z <= stack[sp-1], sp <= sp-1; carry cleared.
REQ-024 RET with sp==0 (empty): z and sp unchanged, err <= 1.
REQ-025 CLR: z <= RESET_ADDR, sp <= 0, err <= 0, carry <= 0.
REQ-026 zflag SHALL always equal (z==0) in the same cycle as z, including after reset.
REQ-027 err SHALL stay 1 until rst or CLR; no other command clears it.
REQ-028 Stack contents beyond sp SHALL be don't-care and never observable on z.

Reset
REQ-029 rst=1 at a clk edge SHALL set z=RESET_ADDR, zflag=(RESET_ADDR==0), carry=0, sp=0, err=0.
REQ-030 rst SHALL take priority over en/cmd in the same cycle; an in-flight command is discarded.
REQ-031 Stack storage need not be reset.

Configuration
REQ-032 Macro ADDR_SEQ_STACK_EN defined: return stack, CALL, RET, sp and err behave per REQ-021..024, REQ-027.
REQ-033 Macro ADDR_SEQ_STACK_EN undefined: no stack storage; CALL behaves as LOAD; RET behaves as NOP; sp and err tied to 0.

Verification
REQ-034 WIDTH=8: rst; en=1 INC x3 -> z=3, zflag=0, carry=0; en=0 with cmd=INC for 2 cycles -> z stays 3.
REQ-035 WIDTH=8: LOAD x=0xFF then INC -> z=0x00, zflag=1, carry=1; then DEC -> z=0xFF, carry=1; then NOP -> carry=0.
REQ-036 WIDTH=8: LOAD 0xF0 then ADD x=0x20 -> z=0x10, carry=1; ADD x=0x01 -> z=0x11, carry=0.
REQ-037 STACK_EN, DEPTH=2: LOAD 0x10, CALL 0x40, CALL 0x80 -> sp=2, z=0x80; CALL 0xC0 -> z=0x80, sp=2, err=1; RET -> z=0x41, sp=1; RET -> z=0x11, sp=0; RET -> z=0x11, err still 1; CLR -> z=RESET_ADDR, err=0.
REQ-038 RESET_ADDR=0x20: CALL 0x40 then rst=1 with en=1 cmd=RET same cycle -> z=0x20, sp=0, err=0, zflag=0.
REQ-039 STACK_EN undefined: CALL 0x33 -> z=0x33, sp=0; RET -> z=0x33, err=0.
